// File: rtl/jt1942_dwnld_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jt1942_dwnld_pkg
// Description : Shared constants, types and decode helpers for the jt1942
//               download stage: PROM map, PROM indices, FSM encoding and the
//               address-region classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package jt1942_dwnld_pkg;

  // PROM area map: the PROMs follow the ROM area directly (end of OBJ region)
  localparam logic [21:0] PROM_START = 22'h3A000;
  localparam logic [8:0]  PROM_LEN   = 9'd256;
  localparam int          PROM_N     = 10;
  localparam logic [21:0] PROM_END   = PROM_START + 22'(PROM_N) * 22'(PROM_LEN);

  // Bit positions inside prom_we; this is the fixed download order
  localparam int PROM_K6  = 0;
  localparam int PROM_D1  = 1;
  localparam int PROM_D2  = 2;
  localparam int PROM_D6  = 3;
  localparam int PROM_E8  = 4;
  localparam int PROM_E9  = 5;
  localparam int PROM_E10 = 6;
  localparam int PROM_F1  = 7;
  localparam int PROM_K3  = 8;
  localparam int PROM_M11 = 9;

  // ROM write FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Region of a download byte
  typedef enum logic [1:0] {
    REGION_ROM  = 2'd0,
    REGION_PROM = 2'd1,
    REGION_NONE = 2'd2
  } region_t;

  function automatic region_t region_of(input logic [21:0] a);
    if (a < PROM_START) begin
      return REGION_ROM;
    end else if (a < PROM_END) begin
      return REGION_PROM;
    end
    return REGION_NONE;
  endfunction

  // Which PROM a byte inside the PROM area belongs to (256 bytes each)
  function automatic logic [3:0] prom_index(input logic [21:0] a);
    return 4'((a - PROM_START) >> 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jt1942_dwnld_if.sv
`default_nettype none
// ============================================================================
// Module      : jt1942_dwnld_if
// Description : SDRAM programming bus between the download stage and the
//               SDRAM controller.
//   prog_addr [21:0] : word address
//   prog_data [15:0] : write data (byte replicated on both halves)
//   prog_mask [1:0]  : byte enable, 1 = write (bit0 low/even, bit1 high/odd)
//   prog_we          : write request, held until accepted
//   prog_rdy         : one-cycle accept pulse from the controller
//   master : download stage side; slave : SDRAM controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface jt1942_dwnld_if;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_rdy;

  modport master (
    output prog_addr,
    output prog_data,
    output prog_mask,
    output prog_we,
    input  prog_rdy
  );

  modport slave (
    input  prog_addr,
    input  prog_data,
    input  prog_mask,
    input  prog_we,
    output prog_rdy
  );
endinterface
`default_nettype wire

// File: rtl/jt1942_dwnld_prom.sv
`default_nettype none
// ============================================================================
// Module      : jt1942_dwnld_prom
// Description : Region decode of the current download address and the
//               registered one-hot PROM write strobe (latency 1).
//   clk, rst        : clock, synchronous active-high reset
//   accept          : a download byte is valid this cycle
//   addr [21:0]     : byte address
//   din  [3:0]      : low nibble of the byte (PROMs are 4 bits wide)
//   region          : combinational region of addr (ROM / PROM / none)
//   prom_addr [7:0] : registered PROM byte address, held until next PROM byte
//   prom_din  [3:0] : registered PROM data, held until next PROM byte
//   prom_we   [9:0] : one-cycle one-hot strobe, bit0 = k6 ... bit9 = m11
// Revision    : 1.0 - initial release
// ============================================================================
module jt1942_dwnld_prom
  import jt1942_dwnld_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic [21:0]       addr,
  input  logic [3:0]        din,
  output region_t           region,
  output logic [7:0]        prom_addr,
  output logic [3:0]        prom_din,
  output logic [PROM_N-1:0] prom_we
);

  logic              prom_byte;
  logic [3:0]        idx;
  logic [PROM_N-1:0] we_next;

  assign region    = region_of(addr);
  assign prom_byte = accept && (region == REGION_PROM);
  assign idx       = prom_index(addr);

  generate
    for (genvar i = 0; i < PROM_N; i++) begin : g_prom_we
      assign we_next[i] = prom_byte && (idx == 4'(i));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      prom_we   <= '0;
      prom_addr <= '0;
      prom_din  <= '0;
    end else begin
      prom_we <= we_next;
      if (prom_byte) begin
        prom_addr <= addr[7:0];
        prom_din  <= din;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/jt1942_dwnld.sv
`default_nettype none
// ============================================================================
// Module      : jt1942_dwnld
// Description : Download stage for jt1942_game. Turns the ioctl byte stream
//               into SDRAM write requests (ROM area) and PROM write strobes,
//               and produces the busy/done download status.
//   clk, rst          : clock, synchronous active-high reset
//   downloading       : download window from the framework
//   ioctl_wr          : one-cycle byte strobe (used only while downloading)
//   ioctl_addr [21:0] : byte address
//   ioctl_data [7:0]  : byte value
//   prog              : SDRAM programming bus (jt1942_dwnld_if.master)
//   prom_addr [7:0]   : PROM byte address
//   prom_din  [3:0]   : PROM data nibble
//   prom_we   [9:0]   : one-hot PROM strobe
//   dwn_busy          : registered downloading | prog_we
//   dwn_done          : one-cycle pulse when dwn_busy falls
//   overrun           : sticky, a ROM byte was lost
//   cksum [15:0]      : only with JT1942_DWNLD_CKSUM_EN; running byte sum
// Optional feature macro: JT1942_DWNLD_CKSUM_EN
// Revision    : 1.0 - initial release
// ============================================================================
module jt1942_dwnld
  import jt1942_dwnld_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic              ioctl_wr,
  input  logic [21:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  jt1942_dwnld_if.master    prog,
  output logic [7:0]        prom_addr,
  output logic [3:0]        prom_din,
  output logic [PROM_N-1:0] prom_we,
  output logic              dwn_busy,
  output logic              dwn_done,
  output logic              overrun
`ifdef JT1942_DWNLD_CKSUM_EN
  ,
  output logic [15:0]       cksum
`endif
);

  state_t      state, state_next;
  region_t     region;
  logic        accept;
  logic        rom_byte;
  logic        load;      // capture the current ROM byte into the request
  logic        drop;      // ROM byte arrives while the request is still pending
  logic        dl_q;
  logic        dl_rise;
  logic        busy_next;
  logic [21:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;

  assign accept  = downloading && ioctl_wr;
  assign dl_rise = downloading && !dl_q;

  jt1942_dwnld_prom u_prom (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .addr      (ioctl_addr),
    .din       (ioctl_data[3:0]),
    .region    (region),
    .prom_addr (prom_addr),
    .prom_din  (prom_din),
    .prom_we   (prom_we)
  );

  assign rom_byte = accept && (region == REGION_ROM);

  // ---------------------------------------------------------------------
  // ROM write FSM. WRITE and FLUSH share the acceptance handling; FLUSH
  // only marks that the download window closed with a request pending.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (rom_byte) begin
          load       = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE, FLUSH: begin
        if (prog.prog_rdy) begin
          // A byte landing in the accept cycle is chained without a gap
          if (rom_byte) begin
            load       = 1'b1;
            state_next = WRITE;
          end else begin
            state_next = IDLE;
          end
        end else if (rom_byte) begin
          drop = 1'b1;
        end else if (!downloading) begin
          state_next = FLUSH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign prog.prog_we   = (state != IDLE);
  assign prog.prog_addr = wr_addr;
  assign prog.prog_data = wr_data;
  assign prog.prog_mask = wr_mask;

  // Request fields and status
  assign busy_next = downloading || prog.prog_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_mask  <= '0;
      overrun  <= 1'b0;
      dl_q     <= 1'b0;
      dwn_busy <= 1'b0;
      dwn_done <= 1'b0;
    end else begin
      if (load) begin
        wr_addr <= {1'b0, ioctl_addr[21:1]};
        wr_data <= {ioctl_data, ioctl_data};
        wr_mask <= ioctl_addr[0] ? 2'b10 : 2'b01;
      end
      // A lost byte wins over the clear so it is never hidden
      if (drop) begin
        overrun <= 1'b1;
      end else if (dl_rise) begin
        overrun <= 1'b0;
      end
      dl_q     <= downloading;
      dwn_busy <= busy_next;
      dwn_done <= dwn_busy && !busy_next;
    end
  end

`ifdef JT1942_DWNLD_CKSUM_EN
  // Sum of bytes that actually reached ROM or PROM; restarts per download
  logic [15:0] cksum_base;
  logic        counted;

  assign cksum_base = dl_rise ? 16'd0 : cksum;
  assign counted    = load || (accept && (region == REGION_PROM));

  always_ff @(posedge clk) begin
    if (rst) begin
      cksum <= '0;
    end else if (counted) begin
      cksum <= cksum_base + 16'(ioctl_data);
    end else begin
      cksum <= cksum_base;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_jt1942_dwnld.sv
`default_nettype none
// ============================================================================
// Module      : tb_jt1942_dwnld
// Description : Self-checking bench for jt1942_dwnld. A vector table covers
//               single bytes in every region; hand sequences cover
//               back-to-back, overrun, flush and reset corners. SDRAM writes
//               and PROM strobes are checked against a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jt1942_dwnld;
  import jt1942_dwnld_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        downloading;
  logic        ioctl_wr;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [7:0]  prom_addr;
  logic [3:0]  prom_din;
  logic [9:0]  prom_we;
  logic        dwn_busy;
  logic        dwn_done;
  logic        overrun;
`ifdef JT1942_DWNLD_CKSUM_EN
  logic [15:0] cksum;
`endif

  always #5 clk = ~clk;

  jt1942_dwnld_if prog ();

  jt1942_dwnld dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .prog        (prog),
    .prom_addr   (prom_addr),
    .prom_din    (prom_din),
    .prom_we     (prom_we),
    .dwn_busy    (dwn_busy),
    .dwn_done    (dwn_done),
    .overrun     (overrun)
`ifdef JT1942_DWNLD_CKSUM_EN
    ,
    .cksum       (cksum)
`endif
  );

  // kind: 0 = ROM, 1 = PROM, 2 = discarded
  typedef struct {
    logic [21:0] a;
    logic [7:0]  d;
    int          kind;
    logic [21:0] pa;
    logic [15:0] pd;
    logic [1:0]  pm;
    logic [9:0]  pw;
    logic [7:0]  pra;
    logic [3:0]  prd;
  } vec_t;

  typedef struct {
    logic [21:0] pa;
    logic [15:0] pd;
    logic [1:0]  pm;
  } rom_exp_t;

  typedef struct {
    logic [9:0] pw;
    logic [7:0] pra;
    logic [3:0] prd;
  } prom_exp_t;

  localparam int NV = 11;
  vec_t      vecs [NV];
  rom_exp_t  rom_q [$];
  prom_exp_t prom_q [$];
  int        checks = 0;
  int        errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_rom(input logic [21:0] pa, input logic [15:0] pd, input logic [1:0] pm);
    rom_exp_t e;
    e.pa = pa; e.pd = pd; e.pm = pm;
    rom_q.push_back(e);
  endtask

  task automatic push_prom(input logic [9:0] pw, input logic [7:0] pra, input logic [3:0] prd);
    prom_exp_t e;
    e.pw = pw; e.pra = pra; e.prd = prd;
    prom_q.push_back(e);
  endtask

  // Scoreboard: compare every accepted SDRAM write and every PROM strobe
  task automatic monitor();
    rom_exp_t  re;
    prom_exp_t pe;
    if (prog.prog_we && prog.prog_rdy) begin
      if (rom_q.size() == 0) begin
        chk("rom_unexpected", 64'({prog.prog_addr, prog.prog_data, prog.prog_mask}), 64'd0);
      end else begin
        re = rom_q.pop_front();
        chk("rom_write", 64'({prog.prog_addr, prog.prog_data, prog.prog_mask}),
            64'({re.pa, re.pd, re.pm}));
      end
    end
    if (prom_we != 10'd0) begin
      if (prom_q.size() == 0) begin
        chk("prom_unexpected", 64'({prom_we, prom_addr, prom_din}), 64'd0);
      end else begin
        pe = prom_q.pop_front();
        chk("prom_write", 64'({prom_we, prom_addr, prom_din}), 64'({pe.pw, pe.pra, pe.prd}));
      end
    end
  endtask

  // Outputs sampled at negedge; inputs change 1 time unit after posedge
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [21:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   hi;
    int   dn;

    vecs[0]  = '{22'h00010, 8'hA5, 0, 22'h00008, 16'hA5A5, 2'b01, 10'h000, 8'h00, 4'h0};
    vecs[1]  = '{22'h3A105, 8'h3C, 1, 22'h0,     16'h0,    2'b00, 10'h002, 8'h05, 4'hC};
    vecs[2]  = '{22'h00011, 8'h5A, 0, 22'h00008, 16'h5A5A, 2'b10, 10'h000, 8'h00, 4'h0};
    vecs[3]  = '{22'h3A000, 8'hF1, 1, 22'h0,     16'h0,    2'b00, 10'h001, 8'h00, 4'h1};
    vecs[4]  = '{22'h39FFF, 8'h77, 0, 22'h1CFFF, 16'h7777, 2'b10, 10'h000, 8'h00, 4'h0};
    vecs[5]  = '{22'h3A9FF, 8'hE8, 1, 22'h0,     16'h0,    2'b00, 10'h200, 8'hFF, 4'h8};
    vecs[6]  = '{22'h3AA00, 8'h11, 2, 22'h0,     16'h0,    2'b00, 10'h000, 8'h00, 4'h0};
    vecs[7]  = '{22'h3FFFF, 8'h22, 2, 22'h0,     16'h0,    2'b00, 10'h000, 8'h00, 4'h0};
    vecs[8]  = '{22'h3A5AB, 8'h96, 1, 22'h0,     16'h0,    2'b00, 10'h020, 8'hAB, 4'h6};
    vecs[9]  = '{22'h2ABCD, 8'hC3, 0, 22'h155E6, 16'hC3C3, 2'b10, 10'h000, 8'h00, 4'h0};
    vecs[10] = '{22'h12344, 8'h0F, 0, 22'h091A2, 16'h0F0F, 2'b01, 10'h000, 8'h00, 4'h0};

    rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_data = '0; prog.prog_rdy = 1'b0;
    @(posedge clk); #1;
    tick(); tick();
    chk("reset_prog", 64'({prog.prog_we, prog.prog_addr, prog.prog_data, prog.prog_mask}), 64'd0);
    chk("reset_prom_status", 64'({prom_we, prom_addr, prom_din, dwn_busy, dwn_done, overrun}), 64'd0);
    rst = 1'b0;
    tick();

    // Busy rises one cycle after downloading
    downloading = 1'b1;
    chk("busy_before_reg", 64'(dwn_busy), 64'd0);
    tick();
    chk("busy_after_rise", 64'(dwn_busy), 64'd1);

    // Single bytes from the table
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      if (v.kind == 0) push_rom(v.pa, v.pd, v.pm);
      else if (v.kind == 1) push_prom(v.pw, v.pra, v.prd);
      send(v.a, v.d);
      if (v.kind == 0) begin
        hi = 0;
        for (int c = 0; c < 4; c++) begin
          if (prog.prog_we) hi++;
          if (c == 3) prog.prog_rdy = 1'b1;
          tick();
        end
        prog.prog_rdy = 1'b0;
        chk("rom_we_cycles", 64'(hi), 64'd4);
        chk("rom_we_release", 64'(prog.prog_we), 64'd0);
      end else if (v.kind == 1) begin
        chk("prom_no_prog_we", 64'(prog.prog_we), 64'd0);
        tick();
        chk("prom_we_one_cycle", 64'(prom_we), 64'd0);
        chk("prom_addr_hold", 64'({prom_addr, prom_din}), 64'({v.pra, v.prd}));
      end else begin
        chk("discard_prog_we", 64'(prog.prog_we), 64'd0);
        chk("discard_prom_we", 64'(prom_we), 64'd0);
        tick();
      end
      tick();
    end

    // Back-to-back: new ROM byte in the accept cycle
    push_rom(22'h00010, 16'h1111, 2'b01);
    send(22'h00020, 8'h11);
    chk("b2b_first_we", 64'(prog.prog_we), 64'd1);
    push_rom(22'h00010, 16'h2222, 2'b10);
    prog.prog_rdy = 1'b1;
    send(22'h00021, 8'h22);
    prog.prog_rdy = 1'b0;
    chk("b2b_we_held", 64'(prog.prog_we), 64'd1);
    chk("b2b_mask", 64'(prog.prog_mask), 64'd2);
    tick();
    chk("b2b_we_still", 64'(prog.prog_we), 64'd1);
    prog.prog_rdy = 1'b1;
    tick();
    prog.prog_rdy = 1'b0;
    chk("b2b_we_release", 64'(prog.prog_we), 64'd0);
    chk("b2b_no_overrun", 64'(overrun), 64'd0);
    tick();

    // Overrun: PROM byte while pending is harmless, second ROM byte is lost
    push_rom(22'h00018, 16'h3333, 2'b01);
    send(22'h00030, 8'h33);
    push_prom(10'h004, 8'h01, 4'hE);
    send(22'h3A201, 8'h5E);
    chk("prom_no_overrun", 64'(overrun), 64'd0);
    send(22'h00031, 8'h44);
    chk("overrun_set", 64'(overrun), 64'd1);
    chk("overrun_req_kept", 64'({prog.prog_addr, prog.prog_data, prog.prog_mask}),
        64'({22'h00018, 16'h3333, 2'b01}));
    tick(); tick();
    chk("overrun_sticky", 64'(overrun), 64'd1);
    prog.prog_rdy = 1'b1;
    tick();
    prog.prog_rdy = 1'b0;
    chk("overrun_accept_we", 64'(prog.prog_we), 64'd0);
    chk("overrun_after_accept", 64'(overrun), 64'd1);
    downloading = 1'b0;
    tick(); tick(); tick();
    chk("overrun_hold_low", 64'(overrun), 64'd1);
    downloading = 1'b1;
    tick();
    chk("overrun_cleared", 64'(overrun), 64'd0);
    tick();

    // Flush: window closes with a write pending, accept 5 cycles later
    push_rom(22'h00020, 16'h5555, 2'b01);
    send(22'h00040, 8'h55);
    downloading = 1'b0;
    dn = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (dwn_done) dn++;
      chk("flush_busy", 64'(dwn_busy), 64'd1);
    end
    chk("flush_we_held", 64'(prog.prog_we), 64'd1);
    prog.prog_rdy = 1'b1;
    tick();
    prog.prog_rdy = 1'b0;
    if (dwn_done) dn++;
    chk("flush_busy_after_accept", 64'(dwn_busy), 64'd1);
    chk("flush_we_release", 64'(prog.prog_we), 64'd0);
    tick();
    if (dwn_done) dn++;
    chk("flush_busy_fall", 64'(dwn_busy), 64'd0);
    tick();
    if (dwn_done) dn++;
    tick();
    chk("flush_done_once", 64'(dn), 64'd1);

    // Download restarts while in FLUSH: no done pulse
    downloading = 1'b1;
    tick();
    push_rom(22'h00028, 16'h6666, 2'b01);
    send(22'h00050, 8'h66);
    downloading = 1'b0;
    dn = 0;
    tick(); tick();
    downloading = 1'b1;
    tick();
    if (dwn_done) dn++;
    prog.prog_rdy = 1'b1;
    tick();
    prog.prog_rdy = 1'b0;
    if (dwn_done) dn++;
    chk("reflush_we_release", 64'(prog.prog_we), 64'd0);
    tick();
    if (dwn_done) dn++;
    tick();
    if (dwn_done) dn++;
    chk("reflush_no_done", 64'(dn), 64'd0);
    chk("reflush_busy", 64'(dwn_busy), 64'd1);

    // Reset in WRITE with overrun set and a PROM byte on the same edge
    send(22'h00060, 8'h77);
    send(22'h00061, 8'h78);
    chk("pre_reset_overrun", 64'(overrun), 64'd1);
    rst        = 1'b1;
    ioctl_wr   = 1'b1;
    ioctl_addr = 22'h3A300;
    ioctl_data = 8'h12;
    tick();
    ioctl_wr    = 1'b0;
    downloading = 1'b0;
    chk("rst_prog_we", 64'(prog.prog_we), 64'd0);
    chk("rst_prom_we", 64'(prom_we), 64'd0);
    chk("rst_status", 64'({dwn_busy, overrun, dwn_done}), 64'd0);
    tick();
    rst = 1'b0;
    dn  = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (dwn_done) dn++;
    end
    chk("rst_no_done", 64'(dn), 64'd0);

    chk("rom_queue_empty", 64'(rom_q.size()), 64'd0);
    chk("prom_queue_empty", 64'(prom_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
